// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1/PC-2 selection tables, per-round shift amounts
// and the half-register rotate helpers shared by the schedule and its PC-2 stage.
package des_pkg;

  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 56;
  localparam int KEY_W    = 64;

  typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

  // Table entries use DES 1-based bit numbers, where bit 1 is the MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFT[i] is the left rotation that turns C(i),D(i) into C(i+1),D(i+1).
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < CD_W; i++) begin
      cd[6'(CD_W - 1 - i)] = key[6'(KEY_W - PC1[i])];
    end
    return cd;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]} : {v[HALF_W-2:0], v[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[1:0], v[HALF_W-1:2]} : {v[0], v[HALF_W-1:1]};
  endfunction

endpackage

// File: rtl/des_pc2_48.sv
// PC-2 compression of the 56-bit C,D pair into a 48-bit round subkey.
// Purely combinational; no flow control.
module des_pc2_48
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  input  logic                unused_clk_tie,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[6'(SUBKEY_W - 1 - i)] = cd[6'(CD_W - PC2[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey source: one load, then one subkey per advance, K1..K16 or K16..K1.
// Latency: subkey valid the cycle after load; no backpressure beyond round_adv_i pacing.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                key_load_i,
  input  logic [KEY_W-1:0]    key_i,
  input  logic                decrypt_i,
  input  logic                round_adv_i,
  output logic [SUBKEY_W-1:0] subkey_o,
  output logic                subkey_valid_o,
  output logic [3:0]          round_o,
  output logic                last_round_o
);

  state_t            state;
  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic [3:0]        round_q;
  logic              dir_q;

  logic [CD_W-1:0]   pc1_cd;
  logic [1:0]        shamt;
  logic              unused_parity;

  assign pc1_cd = pc1(key_i);

  // Parity bits never reach PC-1; folding them here keeps them visibly accounted for.
  assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8],  key_i[0]};

  // Decrypt walks backwards, undoing the shift that produced the current subkey.
  assign shamt = dir_q ? SHIFT[4'd15 - round_q] : SHIFT[round_q + 4'd1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
    end else if (key_load_i) begin
      state   <= ST_ACTIVE;
      round_q <= '0;
      dir_q   <= decrypt_i;
      if (decrypt_i) begin
        c_q <= pc1_cd[CD_W-1:HALF_W];
        d_q <= pc1_cd[HALF_W-1:0];
      end else begin
        c_q <= rotl(pc1_cd[CD_W-1:HALF_W], 2'd1);
        d_q <= rotl(pc1_cd[HALF_W-1:0], 2'd1);
      end
    end else if (round_adv_i && state == ST_ACTIVE) begin
      if (round_q == 4'd15) begin
        state   <= ST_IDLE;
        round_q <= '0;
      end else begin
        round_q <= round_q + 4'd1;
        if (dir_q) begin
          c_q <= rotr(c_q, shamt);
          d_q <= rotr(d_q, shamt);
        end else begin
          c_q <= rotl(c_q, shamt);
          d_q <= rotl(d_q, shamt);
        end
      end
    end
  end

  des_pc2_48 u_pc2 (
    .cd             ({c_q, d_q}),
    .unused_clk_tie (unused_parity),
    .subkey         (subkey_o)
  );

  assign subkey_valid_o = (state == ST_ACTIVE);
  assign round_o        = round_q;
  assign last_round_o   = (state == ST_ACTIVE) && (round_q == 4'd15);

endmodule
